wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 67 ++++++
 tb/tb_wb_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter feeding one registered register-file write port; WB_ARB_WRCOUNT_EN adds a committed-write counter
module wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int RA_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*RA_WIDTH-1:0] req_rd,
  input  logic [NREQ*XLEN-1:0]     req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     rf_busy,
  output logic                     rf_we,
  output logic [RA_WIDTH-1:0]      rf_addr,
  output logic [XLEN-1:0]          rf_data,
  output logic [31:0]              wr_count
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [PW-1:0] ptr, gidx;
  logic hit;
  int best;
  logic [RA_WIDTH-1:0] sel_rd;
  logic [XLEN-1:0] sel_data;
  // pick the valid requester closest to ptr going upward with wrap, then mux its payload
  always_comb begin
    best = NREQ;
    gidx = '0;
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && (i + NREQ - int'(ptr)) % NREQ < best) begin
        best = (i + NREQ - int'(ptr)) % NREQ;
        gidx = PW'(i);
      end
    hit = rst && !rf_busy && best < NREQ;
    req_ready = hit ? NREQ'(1) << gidx : '0;
    sel_rd = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (gidx == PW'(i)) begin
        sel_rd = req_rd[i*RA_WIDTH +: RA_WIDTH];
        sel_data = req_data[i*XLEN +: XLEN];
      end
  end
  // register the accepted write; x0 loads address/data but never raises rf_we
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ptr <= '0;
      rf_we <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      rf_we <= hit && sel_rd != '0;
      if (hit) begin
        ptr <= gidx == PW'(NREQ-1) ? '0 : gidx + 1'b1;
        rf_addr <= sel_rd;
        rf_data <= sel_data;
      end
    end
`ifdef WB_ARB_WRCOUNT_EN
  // count cycles in which a register-file write is presented
  always_ff @(posedge clk or negedge rst)
    if (!rst) wr_count <= '0;
    else if (rf_we) wr_count <= wr_count + 32'd1;
`else
  assign wr_count = '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a round-robin reference model
module tb_wb_arbiter;
  localparam int NREQ = 3, XLEN = 32, RA = 5;
  logic clk = 1'b0, rst = 1'b1, rf_busy = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*RA-1:0] req_rd = '0;
  logic [NREQ*XLEN-1:0] req_data = '0;
  logic [NREQ-1:0] req_ready;
  logic rf_we;
  logic [RA-1:0] rf_addr;
  logic [XLEN-1:0] rf_data;
  logic [31:0] wr_count;
  int checks = 0, errors = 0;
  int m_ptr, last_g, pre_ptr;
  logic [31:0] m_cnt;
  logic m_we;
  logic [RA-1:0] m_addr;
  logic [XLEN-1:0] m_data;

  wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .RA_WIDTH(RA)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .rf_busy(rf_busy), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_data(rf_data), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef WB_ARB_WRCOUNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  function automatic int winner();
    if (rf_busy || !rst) return -1;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_we = 0; m_addr = 0; m_data = 0; last_g = -1;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_we"}, rf_we, m_we);
    chk({tag, "_addr"}, rf_addr, m_addr);
    chk({tag, "_data"}, rf_data, m_data);
    chk({tag, "_cnt"}, wr_count, exp_cnt());
  endtask

  task automatic cycle(input string tag);
    int g;
    @(negedge clk);
    g = winner();
    chk({tag, "_ready"}, req_ready, g < 0 ? 0 : (1 << g));
    @(posedge clk);
    if (m_we) m_cnt = m_cnt + 1;
    if (g >= 0) begin
      m_addr = req_rd[g*RA +: RA];
      m_data = req_data[g*XLEN +: XLEN];
      m_we = m_addr != 0;
      m_ptr = (g + 1) % NREQ;
    end else m_we = 0;
    last_g = g;
    #1;
    chk_outputs(tag);
  endtask

  task automatic set_req(input int i, input logic v, input logic [RA-1:0] rd, input logic [XLEN-1:0] d);
    req_valid[i] = v;
    req_rd[i*RA +: RA] = rd;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_ready", req_ready, 0);
    chk_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    req_valid = '1;
    do_reset();
    set_req(0, 1, 1, 32'hA1); set_req(1, 1, 2, 32'hB2); set_req(2, 1, 3, 32'hC3);
    for (int i = 0; i < 3; i++) begin
      cycle("order");
      chk("order_grant", last_g, i);
      chk("order_addr", rf_addr, i + 1);
    end
    req_valid = '0;
    cycle("drain");
    set_req(2, 1, 7, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      cycle("solo");
      chk("solo_addr", rf_addr, 7);
      chk("solo_we", rf_we, 1);
    end
    req_valid = '0;
    set_req(1, 1, 0, 32'h1234);
    cycle("x0");
    chk("x0_we", rf_we, 0);
    chk("x0_data", rf_data, 32'h1234);
    req_valid = '0;
    cycle("x0_idle");
    set_req(0, 1, 4, 32'h44); set_req(1, 1, 5, 32'h55); set_req(2, 1, 6, 32'h66);
    cycle("prestall");
    rf_busy = 1'b1;
    pre_ptr = m_ptr;
    for (int i = 0; i < 4; i++) cycle("stall");
    chk("stall_we", rf_we, 0);
    rf_busy = 1'b0;
    cycle("resume");
    chk("resume_grant", last_g, pre_ptr);
    req_valid = '0;
    set_req(0, 1, 5, 32'h5555);
    @(negedge clk);
    chk("mid_ready", req_ready, 1 << m_ptr == 1 ? 1 : req_ready);
    chk("mid_ready0", req_ready[0], 1);
    rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_ready", req_ready, 0);
    chk_outputs("mid_rst");
    @(posedge clk);
    #1;
    chk_outputs("mid_hold");
    rst = 1'b1;
    req_valid = '1;
    set_req(1, 1, 9, 32'h99); set_req(2, 1, 10, 32'hAA);
    cycle("post_rst");
    chk("post_rst_grant", last_g, 0);
    req_valid = '0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      set_req(0, 1, (i % 6 == 5) ? 5'd0 : RA'(i + 1), 32'(i * 17));
      cycle("cnt");
    end
    req_valid = '0;
    cycle("cnt_idle");
    cycle("cnt_idle");
`ifdef WB_ARB_WRCOUNT_EN
    chk("cnt_total", wr_count, 10);
`else
    chk("cnt_total", wr_count, 0);
`endif
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] || last_g == i)
          set_req(i, 1'($urandom_range(0, 1)), RA'($urandom_range(0, 7)), $urandom);
      rf_busy = $urandom_range(0, 3) == 0;
      cycle("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
